// File: rtl/cpu_bus_sched_pkg.sv
// Shared types and phase constants for the CPU bus scheduler.
// The phase counter is sized for the largest legal divider (16).
package cpu_bus_sched_pkg;

    localparam int PH_W = 4;

    typedef logic [PH_W-1:0] ph_t;

    typedef enum logic {
        RUN,
        HALTED
    } sched_state_t;

    localparam ph_t CPU_PH = ph_t'(0);
    localparam ph_t RET_PH = ph_t'(1);

    function automatic logic ram_hit(
        input logic [15:0] ab,
        input logic [15:0] base,
        input int          aw
    );
        return (ab >> aw) == (base >> aw);
    endfunction

endpackage

// File: rtl/cpu_bus_sched_phase.sv
// cpu_phase_gen: phase counter and registered CPU clock-enable strobe.
// cpu_en is high during the last phase so the CPU bus moves at phase 0.
module cpu_phase_gen
    import cpu_bus_sched_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output ph_t  ph,
    output logic cpu_en
);

    localparam ph_t LAST = ph_t'(CLK_DIV - 1);
    localparam ph_t PRE  = ph_t'(CLK_DIV - 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph     <= '0;
            cpu_en <= 1'b0;
        end else begin
            ph     <= (ph == LAST) ? '0 : ph + 1'b1;
            cpu_en <= (ph == PRE);
        end
    end

endmodule

// File: rtl/cpu_bus_sched.sv
// cpu_bus_sched: 6502 bus sequencer sharing one synchronous work RAM
// between the CPU, video scan-out and a DMA master that halts the CPU.
module cpu_bus_sched
    import cpu_bus_sched_pkg::*;
#(
    parameter int          CLK_DIV  = 4,
    parameter int          AW       = 11,
    parameter logic [15:0] RAM_BASE = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          cpu_en,
    output logic          cpu_ready,
    input  logic [15:0]   cpu_ab,
    input  logic [7:0]    cpu_dbo,
    input  logic          cpu_we_n,
    input  logic [7:0]    ext_dbi,
    output logic [7:0]    cpu_dbi,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [7:0]    vid_data,
    input  logic          dma_req,
    output logic          dma_ack,
    input  logic [AW-1:0] dma_addr,
    input  logic          dma_we,
    input  logic [7:0]    dma_din,
    output logic          dma_rvalid,
    output logic [7:0]    dma_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout
);

    localparam ph_t LAST = ph_t'(CLK_DIV - 1);

    ph_t          ph;
    sched_state_t state;
    sched_state_t state_d;
    logic         hit;
    logic         vid_issue;

    cpu_phase_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_phase (
        .clk    (clk),
        .rst_n  (rst_n),
        .ph     (ph),
        .cpu_en (cpu_en)
    );

    assign hit       = ram_hit(cpu_ab, RAM_BASE, AW);
    assign cpu_ready = (state == RUN);
    assign dma_ack   = (state == HALTED);
    assign vid_data  = vid_ack ? ram_dout : '0;
    assign dma_rdata = dma_rvalid ? ram_dout : '0;

    // Halt entry waits for a read cycle so a CPU write is never lost.
    always_comb begin
        state_d = state;
        if (ph == LAST) begin
            unique case (state)
                RUN:    if (dma_req && cpu_we_n) state_d = HALTED;
                HALTED: if (!dma_req) state_d = RUN;
            endcase
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_din   = '0;
        vid_issue = 1'b0;
        if (rst_n) begin
            if (ph == CPU_PH) begin
                if (state == RUN) begin
                    ram_addr = cpu_ab[AW-1:0];
                    ram_we   = hit & ~cpu_we_n & cpu_ready;
                    ram_din  = cpu_dbo;
                end else begin
                    ram_addr = dma_addr;
                    ram_we   = dma_we;
                    ram_din  = dma_din;
                end
            end else if (vid_req && !vid_ack) begin
                vid_issue = 1'b1;
                ram_addr  = vid_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            vid_ack    <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_dbi    <= '0;
        end else begin
            state      <= state_d;
            vid_ack    <= vid_issue;
            dma_rvalid <= (ph == CPU_PH) && (state == HALTED) && !dma_we;
            if (ph == RET_PH && state == RUN) begin
                cpu_dbi <= hit ? ram_dout : ext_dbi;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_sched.sv
// Bench for cpu_bus_sched: directed scenarios then random traffic,
// all checked against a cycle-count based reference model.
module tb_cpu_bus_sched;

    localparam int          CLK_DIV  = 4;
    localparam int          AW       = 11;
    localparam logic [15:0] RAM_BASE = 16'h0000;
    localparam int          DEPTH    = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_en;
    logic          cpu_ready;
    logic [15:0]   cpu_ab = 16'h8000;
    logic [7:0]    cpu_dbo = '0;
    logic          cpu_we_n = 1'b1;
    logic [7:0]    ext_dbi = '0;
    logic [7:0]    cpu_dbi;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic [7:0]    vid_data;
    logic          dma_req = 1'b0;
    logic          dma_ack;
    logic [AW-1:0] dma_addr = '0;
    logic          dma_we = 1'b0;
    logic [7:0]    dma_din = '0;
    logic          dma_rvalid;
    logic [7:0]    dma_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;

    always #5 clk = ~clk;

    cpu_bus_sched #(
        .CLK_DIV  (CLK_DIV),
        .AW       (AW),
        .RAM_BASE (RAM_BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_en     (cpu_en),
        .cpu_ready  (cpu_ready),
        .cpu_ab     (cpu_ab),
        .cpu_dbo    (cpu_dbo),
        .cpu_we_n   (cpu_we_n),
        .ext_dbi    (ext_dbi),
        .cpu_dbi    (cpu_dbi),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_data   (vid_data),
        .dma_req    (dma_req),
        .dma_ack    (dma_ack),
        .dma_addr   (dma_addr),
        .dma_we     (dma_we),
        .dma_din    (dma_din),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    function automatic logic [7:0] init_val(input int i);
        if (i == 'h123) return 8'h5A;
        if (i == 'h040) return 8'h3C;
        return 8'(i * 37 + 11);
    endfunction

    logic [7:0] mem [DEPTH];
    bit         loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    int         cyc;
    bit         halted, vack, dval, last_vack;
    logic [7:0] vdata, ddata, cdbi, cpu_pend;
    logic [7:0] ref_mem [DEPTH];

    function automatic bit is_hit(input logic [15:0] a);
        return a[15:AW] == RAM_BASE[15:AW];
    endfunction

    task automatic model_reset();
        cyc = 0;
        halted = 1'b0;
        vack = 1'b0;
        dval = 1'b0;
        cdbi = '0;
        cpu_pend = '0;
        last_vack = 1'b0;
    endtask

    task automatic check_out();
        int p = cyc % CLK_DIV;
        check("cpu_en", 32'(cpu_en), 32'(p == CLK_DIV - 1));
        check("cpu_ready", 32'(cpu_ready), 32'(!halted));
        check("dma_ack", 32'(dma_ack), 32'(halted));
        check("cpu_dbi", 32'(cpu_dbi), 32'(cdbi));
        check("vid_ack", 32'(vid_ack), 32'(vack));
        if (vack) check("vid_data", 32'(vid_data), 32'(vdata));
        check("dma_rvalid", 32'(dma_rvalid), 32'(dval));
        if (dval) check("dma_rdata", 32'(dma_rdata), 32'(ddata));
        if (p == 0 && !halted) begin
            check("ram_addr_cpu", 32'(ram_addr), 32'(cpu_ab[AW-1:0]));
            check("ram_we_cpu", 32'(ram_we),
                  32'(is_hit(cpu_ab) && !cpu_we_n));
            check("ram_din_cpu", 32'(ram_din), 32'(cpu_dbo));
        end else if (p == 0) begin
            check("ram_addr_dma", 32'(ram_addr), 32'(dma_addr));
            check("ram_we_dma", 32'(ram_we), 32'(dma_we));
            check("ram_din_dma", 32'(ram_din), 32'(dma_din));
        end else begin
            check("ram_we_vid", 32'(ram_we), 32'd0);
            if (vid_req && !vack)
                check("ram_addr_vid", 32'(ram_addr), 32'(vid_addr));
        end
    endtask

    task automatic advance();
        int p = cyc % CLK_DIV;
        bit nv = 1'b0;
        bit nd = 1'b0;
        if (p == 0 && !halted) begin
            cpu_pend = ref_mem[cpu_ab[AW-1:0]];
            if (is_hit(cpu_ab) && !cpu_we_n)
                ref_mem[cpu_ab[AW-1:0]] = cpu_dbo;
        end else if (p == 0 && dma_we) begin
            ref_mem[dma_addr] = dma_din;
        end else if (p == 0) begin
            nd = 1'b1;
            ddata = ref_mem[dma_addr];
        end else if (vid_req && !vack) begin
            nv = 1'b1;
            vdata = ref_mem[vid_addr];
        end
        if (p == 1 && !halted)
            cdbi = is_hit(cpu_ab) ? cpu_pend : ext_dbi;
        if (p == CLK_DIV - 1)
            halted = halted ? dma_req : (dma_req && cpu_we_n);
        vack = nv;
        dval = nd;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_out();
        last_vack = vack;
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic to_ph0();
        while (cyc % CLK_DIV != 0) tick();
    endtask

    task automatic cpu_cycle(input logic [15:0] ab, input logic we_n,
                             input logic [7:0] dbo);
        to_ph0();
        cpu_ab = ab;
        cpu_we_n = we_n;
        cpu_dbo = dbo;
        repeat (CLK_DIV) tick();
        cpu_we_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
        check({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        check({tag, "_dbi"}, 32'(cpu_dbi), 32'd0);
        check({tag, "_vack"}, 32'(vid_ack), 32'd0);
        check({tag, "_vdata"}, 32'(vid_data), 32'd0);
        check({tag, "_dack"}, 32'(dma_ack), 32'd0);
        check({tag, "_rvalid"}, 32'(dma_rvalid), 32'd0);
        check({tag, "_rdata"}, 32'(dma_rdata), 32'd0);
        check({tag, "_raddr"}, 32'(ram_addr), 32'd0);
        check({tag, "_rwe"}, 32'(ram_we), 32'd0);
        check({tag, "_rdin"}, 32'(ram_din), 32'd0);
    endtask

    task automatic drive_random();
        int p = cyc % CLK_DIV;
        ext_dbi = 8'($urandom);
        dma_addr = AW'($urandom);
        dma_we = 1'($urandom);
        dma_din = 8'($urandom);
        if ($urandom_range(0, 39) == 0) dma_req = !dma_req;
        if (p == 0 && !halted) begin
            cpu_ab = ($urandom_range(0, 1) == 1)
                   ? {RAM_BASE[15:AW], AW'($urandom)} : 16'($urandom);
            cpu_we_n = ($urandom_range(0, 2) != 0);
            cpu_dbo = 8'($urandom);
        end
        if (!vid_req) begin
            vid_req = ($urandom_range(0, 2) == 0);
            vid_addr = AW'($urandom);
        end else if (last_vack) begin
            vid_req = 1'($urandom);
            vid_addr = AW'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;

        repeat (8) tick();

        cpu_cycle(16'h0123, 1'b1, 8'h00);
        check("rd_ram_0123", 32'(cpu_dbi), 32'h5A);
        ext_dbi = 8'hC3;
        cpu_cycle(16'h8000, 1'b1, 8'h00);
        check("rd_ext_8000", 32'(cpu_dbi), 32'hC3);

        cpu_cycle(16'h0010, 1'b0, 8'h77);
        check("wr_0010", 32'(mem[11'h010]), 32'h77);
        cpu_cycle(16'h9000, 1'b0, 8'h55);
        check("wr_9000_miss", 32'(mem[11'h000]), 32'(init_val(0)));

        to_ph0();
        vid_req = 1'b1;
        vid_addr = 11'h040;
        tick();
        tick();
        check("vid_ack_ph2", 32'(vid_ack), 32'd1);
        check("vid_data_040", 32'(vid_data), 32'h3C);
        vid_req = 1'b0;

        to_ph0();
        cpu_ab = 16'h0020;
        cpu_we_n = 1'b0;
        cpu_dbo = 8'h99;
        dma_req = 1'b1;
        dma_addr = 11'h200;
        repeat (CLK_DIV) tick();
        check("halt_deferred", 32'(cpu_ready), 32'd1);
        cpu_ab = 16'h8000;
        cpu_we_n = 1'b1;
        repeat (CLK_DIV) tick();
        check("halt_ready", 32'(cpu_ready), 32'd0);
        check("halt_dma_ack", 32'(dma_ack), 32'd1);
        dma_we = 1'b1;
        dma_din = 8'h11;
        tick();
        dma_we = 1'b0;
        repeat (CLK_DIV - 1) tick();
        tick();
        check("dma_rvalid_rb", 32'(dma_rvalid), 32'd1);
        check("dma_rdata_rb", 32'(dma_rdata), 32'h11);
        dma_req = 1'b0;
        to_ph0();
        check("resume_ready", 32'(cpu_ready), 32'd1);

        dma_req = 1'b1;
        repeat (CLK_DIV) tick();
        check("rehalt", 32'(dma_ack), 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        dma_req = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (CLK_DIV) tick();
        check("post_rst_ready", 32'(cpu_ready), 32'd1);

        repeat (1600) begin
            drive_random();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
